decoder_stream: RTL and testbench

Parametrised successor to the registered 3-to-8 decoder. Decodes a SEL_W-bit index into an OUT_W-bit vector in one of three modes (one-hot, one-cold, thermometer) and flags out-of-range indices. Uses valid/ready handshakes on both sides, with a one-cycle output register plus a skid register for full throughput under backpressure. Sits between a control/address source and a select-line consumer in the random-design datapaths.

---
 rtl/decoder_stream.sv | 119 +++++++++++
 tb/tb_decoder_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_stream.sv
// decoder_stream: streaming SEL_W -> OUT_W decoder (one-hot / one-cold /
// thermometer) with range and reserved-mode error flagging.
//
// Input side valid/ready, output side valid/ready. A one-word output
// register plus a one-word skid register keep full throughput under
// backpressure; in_ready is registered and depends only on skid occupancy.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   sel_in, mode_in     index and mode (00 hot, 01 cold, 10 therm, 11 rsvd)
//   out_valid/out_ready output handshake
//   data_out, err_out   decoded vector and error flag
//   err_cnt             saturating error count
//
// Optional macro DECODER_ERRCNT_EN: when defined, err_cnt counts output
// handshakes carrying err_out=1 (saturating); otherwise err_cnt is tied 0.
module decoder_stream #(
   parameter int SEL_W = 3,
   parameter int OUT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] sel_in,
   input  logic [1:0]       mode_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] data_out,
   output logic             err_out,
   output logic [CNT_W-1:0] err_cnt
);

   logic             arm;
   logic             skid_valid;
   logic [OUT_W-1:0] skid_data;
   logic             skid_err;

   logic [OUT_W-1:0] dec_data;
   logic             dec_err;
   logic             in_range;
   logic             accept;
   logic             out_free;
   logic             skid_next;

   // Combinational decode of the word presented on the input
   always_comb begin
      dec_data = '0;
      dec_err  = 1'b0;
      in_range = (int'(sel_in) < OUT_W);
      case (mode_in)
         2'b00: for (int i = 0; i < OUT_W; i++) dec_data[i] = (int'(sel_in) == i);
         2'b01: for (int i = 0; i < OUT_W; i++) dec_data[i] = (int'(sel_in) != i);
         // thermometer must be forced to zero when out of range
         2'b10: for (int i = 0; i < OUT_W; i++) dec_data[i] = in_range && (i <= int'(sel_in));
         default: dec_err = 1'b1;
      endcase
      if (!in_range) dec_err = 1'b1;
   end

   assign accept   = in_valid && in_ready;
   // output register can take a new word this cycle
   assign out_free = !out_valid || out_ready;
   // accept only happens with skid empty, so a draining output always empties the skid
   assign skid_next = out_free ? 1'b0 : (skid_valid || accept);

   always_ff @(posedge clk) begin
      if (rst) begin
         arm        <= 1'b0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         data_out   <= '0;
         err_out    <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_err   <= 1'b0;
      end else begin
         arm        <= 1'b1;
         // uses the old arm so the first post-reset cycle stays not-ready
         in_ready   <= arm && !skid_next;
         skid_valid <= skid_next;
         if (out_free) begin
            if (skid_valid) begin
               out_valid <= 1'b1;
               data_out  <= skid_data;
               err_out   <= skid_err;
            end else if (accept) begin
               out_valid <= 1'b1;
               data_out  <= dec_data;
               err_out   <= dec_err;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_data <= dec_data;
            skid_err  <= dec_err;
         end
      end
   end

`ifdef DECODER_ERRCNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (out_valid && out_ready && err_out && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign err_cnt = cnt;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_stream.sv
module tb_decoder_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   // DUT a: SEL_W=3, OUT_W=8
   logic       a_in_valid = 1'b0;
   logic       a_in_ready;
   logic [2:0] a_sel = '0;
   logic [1:0] a_mode = '0;
   logic       a_out_valid;
   logic       a_out_ready = 1'b1;
   logic [7:0] a_data;
   logic       a_err;
   logic [7:0] a_cnt;

   // DUT b: SEL_W=3, OUT_W=6, CNT_W=2
   logic       b_in_valid = 1'b0;
   logic       b_in_ready;
   logic [2:0] b_sel = '0;
   logic [1:0] b_mode = '0;
   logic       b_out_valid;
   logic       b_out_ready = 1'b1;
   logic [5:0] b_data;
   logic       b_err;
   logic [1:0] b_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decoder_stream #(.SEL_W(3), .OUT_W(8), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .sel_in(a_sel), .mode_in(a_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .data_out(a_data), .err_out(a_err), .err_cnt(a_cnt)
   );

   decoder_stream #(.SEL_W(3), .OUT_W(6), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .sel_in(b_sel), .mode_in(b_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .data_out(b_data), .err_out(b_err), .err_cnt(b_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_in_valid = 1'b1; a_sel = 3'd0; a_mode = 2'b00; a_out_ready = 1'b1;
      repeat (3) step();
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", a_in_ready); end
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", a_out_valid); end
      checks++; if (a_data !== 8'h00 || a_err !== 1'b0) begin errors++; $display("FAIL rst_data got=%h/%0b exp=00/0", a_data, a_err); end
      checks++; if (a_cnt !== 8'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
      rst = 1'b0;
      step();
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL warm1_in_ready got=%0b exp=0", a_in_ready); end
      step();
      checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL warm2 got ir=%0b ov=%0b exp ir=1 ov=0", a_in_ready, a_out_valid); end
      step();
      a_in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b1 || a_data !== 8'h01 || a_err !== 1'b0) begin errors++; $display("FAIL first_out got ov=%0b d=%h e=%0b exp 1/01/0", a_out_valid, a_data, a_err); end
      step();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL first_drain got ov=%0b exp=0", a_out_valid); end
   endtask

   task automatic test_mode_sweep();
      logic [2:0] sv [0:9];
      logic [1:0] mv [0:9];
      logic [7:0] ev [0:9];
      sv = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5, 3'd5};
      mv = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
      ev = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hDF, 8'h3F};
      a_out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         a_in_valid = 1'b1; a_sel = sv[k]; a_mode = mv[k];
         step();
         checks++;
         if (a_out_valid !== 1'b1 || a_data !== ev[k] || a_err !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++; $display("FAIL sweep_%0d got ov=%0b d=%h e=%0b ir=%0b exp 1/%h/0/1", k, a_out_valid, a_data, a_err, a_in_ready, ev[k]);
         end
      end
      a_in_valid = 1'b0;
      step();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got ov=%0b exp=0", a_out_valid); end
   endtask

   task automatic test_range();
      logic [2:0] sv [0:3];
      logic [1:0] mv [0:3];
      logic [5:0] ev [0:3];
      logic       erv [0:3];
      sv  = '{3'd6, 3'd7, 3'd2, 3'd5};
      mv  = '{2'd0, 2'd1, 2'd3, 2'd2};
      ev  = '{6'h00, 6'h3F, 6'h00, 6'h3F};
      erv = '{1'b1, 1'b1, 1'b1, 1'b0};
      b_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b_in_valid = 1'b1; b_sel = sv[k]; b_mode = mv[k];
         step();
         checks++;
         if (b_out_valid !== 1'b1 || b_data !== ev[k] || b_err !== erv[k]) begin
            errors++; $display("FAIL range_%0d got ov=%0b d=%h e=%0b exp 1/%h/%0b", k, b_out_valid, b_data, b_err, ev[k], erv[k]);
         end
      end
      b_in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      a_mode = 2'b00; a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_sel = 3'd1;
      step();
      checks++; if (a_out_valid !== 1'b1 || a_data !== 8'h02) begin errors++; $display("FAIL bp_w0 got ov=%0b d=%h exp 1/02", a_out_valid, a_data); end
      a_out_ready = 1'b0; a_sel = 3'd2;
      step();
      checks++; if (a_data !== 8'h02 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_skidfill got d=%h ir=%0b exp 02/0", a_data, a_in_ready); end
      a_sel = 3'd3;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (a_out_valid !== 1'b1 || a_data !== 8'h02 || a_in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold_%0d got ov=%0b d=%h ir=%0b exp 1/02/0", k, a_out_valid, a_data, a_in_ready);
         end
      end
      a_out_ready = 1'b1;
      step();
      checks++; if (a_out_valid !== 1'b1 || a_data !== 8'h04 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_w1 got ov=%0b d=%h ir=%0b exp 1/04/1", a_out_valid, a_data, a_in_ready); end
      step();
      a_sel = 3'd4;
      checks++; if (a_out_valid !== 1'b1 || a_data !== 8'h08) begin errors++; $display("FAIL bp_w2 got ov=%0b d=%h exp 1/08", a_out_valid, a_data); end
      step();
      a_in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b1 || a_data !== 8'h10) begin errors++; $display("FAIL bp_w3 got ov=%0b d=%h exp 1/10", a_out_valid, a_data); end
      step();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got ov=%0b exp=0", a_out_valid); end
   endtask

   task automatic test_reset_mid();
      a_mode = 2'b00; a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_sel = 3'd1;
      step();
      a_out_ready = 1'b0; a_sel = 3'd2;
      step();
      a_in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got ov=%0b ir=%0b exp 1/0", a_out_valid, a_in_ready); end
      rst = 1'b1;
      step();
      checks++; if (a_out_valid !== 1'b0 || a_data !== 8'h00 || a_in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got ov=%0b d=%h ir=%0b exp 0/00/0", a_out_valid, a_data, a_in_ready); end
      rst = 1'b0; a_out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost_%0d got ov=%0b exp=0", k, a_out_valid); end
      end
   endtask

   task automatic test_errcnt();
      logic [2:0] sv [0:5];
      logic [1:0] mv [0:5];
      logic [1:0] cv [0:5];
      sv = '{3'd6, 3'd7, 3'd1, 3'd6, 3'd7, 3'd2};
      mv = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
`ifdef DECODER_ERRCNT_EN
      cv = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
`else
      cv = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      b_out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         b_in_valid = 1'b1; b_sel = sv[k]; b_mode = mv[k];
         step();
         b_in_valid = 1'b0;
         step();
         checks++;
         if (b_cnt !== cv[k]) begin errors++; $display("FAIL errcnt_%0d got=%0d exp=%0d", k, b_cnt, cv[k]); end
      end
      checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_a got=%0d exp=0", a_cnt); end
   endtask

   initial begin
      test_reset();
      test_mode_sweep();
      test_range();
      test_backpressure();
      test_reset_mid();
      test_errcnt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
